// File: rtl/sdram_pkg.sv
// Shared types and width helpers for the multi-bank SDRAM model.
package sdram_pkg;

  typedef enum logic [2:0] {
    CmdNop          = 3'd0,
    CmdActivate     = 3'd1,
    CmdRead         = 3'd2,
    CmdWrite        = 3'd3,
    CmdPrecharge    = 3'd4,
    CmdPrechargeAll = 3'd5,
    CmdRefresh      = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    BankIdle,
    BankActivating,
    BankActive,
    BankPrecharging
  } bank_state_e;

  // Index width that stays legal for a single-entry dimension.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefBanks   = 4;
  localparam int unsigned DefBankW   = idx_width(DefBanks);
  localparam int unsigned DefRowBits = 8;
  localparam int unsigned DefColBits = 6;

endpackage

// File: rtl/sdram_bank_fsm.sv
// Per-bank state machine: bank state, tRCD/tRP timing counter and open row.
module sdram_bank_fsm import sdram_pkg::*; #(
  parameter int unsigned ROW_BITS = DefRowBits,
  parameter int unsigned T_RCD    = 2,
  parameter int unsigned T_RP     = 2
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                activate_i,
  input  logic                precharge_i,
  input  logic [ROW_BITS-1:0] row_i,
  output bank_state_e         state_o,
  output logic [ROW_BITS-1:0] open_row_o
);

  localparam int unsigned TMax = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned CntW = idx_width(TMax + 1);

  bank_state_e         state_q;
  logic [CntW-1:0]     cnt_q;
  logic [ROW_BITS-1:0] open_row_q;

  // Bank FSM; the wait state ends on the edge where the counter reaches 0, so a
  // command becomes legal exactly T_RCD (or T_RP) cycles after the trigger.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= BankIdle;
      cnt_q      <= '0;
      open_row_q <= '0;
    end else begin
      unique case (state_q)
        BankIdle: begin
          if (activate_i) begin
            open_row_q <= row_i;
            cnt_q      <= CntW'(T_RCD - 1);
            state_q    <= (T_RCD <= 1) ? BankActive : BankActivating;
          end
        end
        BankActivating: begin
          if (cnt_q <= CntW'(1)) begin
            cnt_q   <= '0;
            state_q <= BankActive;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BankActive: begin
          if (precharge_i) begin
            cnt_q   <= CntW'(T_RP - 1);
            state_q <= (T_RP <= 1) ? BankIdle : BankPrecharging;
          end
        end
        BankPrecharging: begin
          if (cnt_q <= CntW'(1)) begin
            cnt_q   <= '0;
            state_q <= BankIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= BankIdle;
      endcase
    end
  end

  assign state_o    = state_q;
  assign open_row_o = open_row_q;

endmodule

// File: rtl/sdram_bank_array.sv
// Multi-bank SDRAM behavioural model: command decode, storage array, CAS read
// pipeline and refresh timing. Optional per-byte write mask: SDRAM_BYTE_MASK_EN.
module sdram_bank_array import sdram_pkg::*; #(
  parameter int unsigned BANKS            = DefBanks,
  parameter int unsigned ROW_BITS         = DefRowBits,
  parameter int unsigned COL_BITS         = DefColBits,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CAS_LATENCY      = 2,
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RFC            = 6,
  parameter int unsigned REFRESH_INTERVAL = 512
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          cmd_valid_i,
  input  cmd_e                          cmd_i,
  input  logic [idx_width(BANKS)-1:0]   bank_i,
  input  logic [ROW_BITS-1:0]           row_addr_i,
  input  logic [COL_BITS-1:0]           col_addr_i,
  input  logic [DATA_WIDTH-1:0]         write_data_i,
`ifdef SDRAM_BYTE_MASK_EN
  input  logic [DATA_WIDTH/8-1:0]       byte_enable_i,
`endif
  output logic                          cmd_ready_o,
  output logic                          read_valid_o,
  output logic [DATA_WIDTH-1:0]         read_data_o,
  output logic                          refresh_due_o,
  output logic                          cmd_error_o
);

  localparam int unsigned BankW = idx_width(BANKS);
  localparam int unsigned AddrW = BankW + ROW_BITS + COL_BITS;
  localparam int unsigned Depth = 2 ** AddrW;
  localparam int unsigned IntW  = idx_width(REFRESH_INTERVAL);
  localparam int unsigned RfcW  = idx_width(T_RFC + 1);
  localparam int unsigned Bytes = DATA_WIDTH / 8;

  bank_state_e          bank_state [BANKS];
  logic [ROW_BITS-1:0]  open_row   [BANKS];
  logic [BANKS-1:0]     act_en, pre_en;

  logic                 accept, legal, do_cmd, do_read, do_write, do_refresh;
  logic                 all_idle, any_activating;
  logic [AddrW-1:0]     addr;
  logic [Bytes-1:0]     be;

  logic [DATA_WIDTH-1:0]  mem_q [Depth];
  logic [CAS_LATENCY-1:0] rd_valid_q;
  logic [DATA_WIDTH-1:0]  rd_data_q [CAS_LATENCY];
  logic [RfcW-1:0]        rfc_q;
  logic [IntW-1:0]        intv_q;
  logic                   cmd_error_q;

`ifdef SDRAM_BYTE_MASK_EN
  assign be = byte_enable_i;
`else
  assign be = '1;
`endif

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    sdram_bank_fsm #(
      .ROW_BITS (ROW_BITS),
      .T_RCD    (T_RCD),
      .T_RP     (T_RP)
    ) u_bank (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .activate_i  (act_en[g]),
      .precharge_i (pre_en[g]),
      .row_i       (row_addr_i),
      .state_o     (bank_state[g]),
      .open_row_o  (open_row[g])
    );
  end

  // Command legality and per-bank strobes; illegal commands produce no strobe.
  always_comb begin
    all_idle       = 1'b1;
    any_activating = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_state[b] != BankIdle)       all_idle = 1'b0;
      if (bank_state[b] == BankActivating) any_activating = 1'b1;
    end
    accept = cmd_valid_i && cmd_ready_o && (cmd_i != CmdNop);
    case (cmd_i)
      CmdActivate:         legal = (bank_state[bank_i] == BankIdle);
      CmdRead, CmdWrite:   legal = (bank_state[bank_i] == BankActive);
      CmdPrecharge:        legal = (bank_state[bank_i] != BankActivating);
      CmdPrechargeAll:     legal = !any_activating;
      CmdRefresh:          legal = all_idle;
      default:             legal = 1'b0;
    endcase
    do_cmd     = accept && legal;
    do_read    = do_cmd && (cmd_i == CmdRead);
    do_write   = do_cmd && (cmd_i == CmdWrite);
    do_refresh = do_cmd && (cmd_i == CmdRefresh);
    for (int b = 0; b < BANKS; b++) begin
      act_en[b] = do_cmd && (cmd_i == CmdActivate) && (bank_i == BankW'(b));
      pre_en[b] = do_cmd && (((cmd_i == CmdPrecharge) && (bank_i == BankW'(b))) ||
                             (cmd_i == CmdPrechargeAll));
    end
    addr = {bank_i, open_row[bank_i], col_addr_i};
  end

  // Storage array; never reset, so contents survive reset.
  always_ff @(posedge clock_i) begin
    if (do_write) begin
      for (int i = 0; i < Bytes; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= write_data_i[8*i +: 8];
      end
    end
  end

  // CAS pipeline: array sampled at the accept edge, shifted CAS_LATENCY-1 more times.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_valid_q <= '0;
      for (int i = 0; i < CAS_LATENCY; i++) rd_data_q[i] <= '0;
    end else begin
      rd_valid_q[0] <= do_read;
      rd_data_q[0]  <= do_read ? mem_q[addr] : '0;
      for (int i = 1; i < CAS_LATENCY; i++) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        rd_data_q[i]  <= rd_data_q[i-1];
      end
    end
  end

  // Refresh busy window, saturating interval counter and error pulse.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rfc_q       <= '0;
      intv_q      <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      cmd_error_q <= accept && !legal;
      if (do_refresh)          rfc_q <= RfcW'(T_RFC);
      else if (rfc_q != '0)    rfc_q <= rfc_q - 1'b1;
      if (do_refresh)                              intv_q <= '0;
      else if (intv_q != IntW'(REFRESH_INTERVAL - 1)) intv_q <= intv_q + 1'b1;
    end
  end

  assign cmd_ready_o   = (rfc_q == '0);
  assign refresh_due_o = (intv_q == IntW'(REFRESH_INTERVAL - 1));
  assign cmd_error_o   = cmd_error_q;
  assign read_valid_o  = rd_valid_q[CAS_LATENCY-1];
  assign read_data_o   = rd_data_q[CAS_LATENCY-1];

endmodule

// File: tb/tb_sdram_bank_array.sv
// Directed self-checking bench for sdram_bank_array (default parameters).
// Builds with or without SDRAM_BYTE_MASK_EN.
module tb_sdram_bank_array;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  cmd_e        cmd;
  logic [1:0]  bank;
  logic [7:0]  row_addr;
  logic [5:0]  col_addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        cmd_ready, read_valid, refresh_due, cmd_error;
  logic [31:0] read_data;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  sdram_bank_array u_dut (
    .clock_i       (clk),
    .reset_i       (reset),
    .cmd_valid_i   (cmd_valid),
    .cmd_i         (cmd),
    .bank_i        (bank),
    .row_addr_i    (row_addr),
    .col_addr_i    (col_addr),
    .write_data_i  (write_data),
`ifdef SDRAM_BYTE_MASK_EN
    .byte_enable_i (byte_enable),
`endif
    .cmd_ready_o   (cmd_ready),
    .read_valid_o  (read_valid),
    .read_data_o   (read_data),
    .refresh_due_o (refresh_due),
    .cmd_error_o   (cmd_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input cmd_e c, input logic [1:0] b, input logic [7:0] r,
                       input logic [5:0] col, input logic [31:0] d, input logic [3:0] be);
    cmd_valid   = 1'b1;
    cmd         = c;
    bank        = b;
    row_addr    = r;
    col_addr    = col;
    write_data  = d;
    byte_enable = be;
    step();
    cmd_valid = 1'b0;
    cmd       = CmdNop;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [1:0]  rb  [8];
  logic [5:0]  rc  [8];
  logic [7:0]  rrow[4];
  logic [31:0] exp_d[8];
  logic [31:0] mask_exp;

  initial begin
    rb   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    rc   = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8};
    rrow = '{8'd9, 8'd5, 8'd7, 8'd11};
    for (int i = 0; i < 8; i++) exp_d[i] = 32'hA000_0000 + 32'(rb[i]) * 256 + 32'(rc[i]);
`ifdef SDRAM_BYTE_MASK_EN
    mask_exp = 32'hFF00_FF00;
`else
    mask_exp = 32'h0000_0000;
`endif

    cmd_valid = 1'b0; cmd = CmdNop; bank = '0; row_addr = '0; col_addr = '0;
    write_data = '0; byte_enable = '0;
    do_reset();

    // Reset values
    check("rst_ready", cmd_ready, 1);
    check("rst_rvalid", read_valid, 0);
    check("rst_rdata", read_data, 0);
    check("rst_due", refresh_due, 0);
    check("rst_err", cmd_error, 0);

    // Basic ACT / WR / RD with write-to-read forwarding through the array
    issue(CmdActivate, 2'd1, 8'd5, 6'd0, 32'h0, 4'hF);
    step();
    issue(CmdWrite, 2'd1, 8'd0, 6'd3, 32'hDEAD_BEEF, 4'hF);
    check("wr_err", cmd_error, 0);
    issue(CmdRead, 2'd1, 8'd0, 6'd3, 32'h0, 4'hF);
    check("rd_err", cmd_error, 0);
    check("rd_lat1", read_valid, 0);
    step();
    check("rd_valid", read_valid, 1);
    check("rd_data", read_data, 32'hDEAD_BEEF);
    step();
    check("rd_done", read_valid, 0);

    // Illegal reads: bank idle, then tRCD not yet met
    issue(CmdRead, 2'd2, 8'd0, 6'd0, 32'h0, 4'hF);
    check("idle_rd_err", cmd_error, 1);
    step();
    check("err_pulse", cmd_error, 0);
    check("idle_rd_nv", read_valid, 0);
    issue(CmdActivate, 2'd2, 8'd7, 6'd0, 32'h0, 4'hF);
    issue(CmdRead, 2'd2, 8'd0, 6'd0, 32'h0, 4'hF);
    check("early_rd_err", cmd_error, 1);
    for (int i = 0; i < 3; i++) begin
      check("early_rd_nv", read_valid, 0);
      step();
    end

    // Open remaining banks, write one word per (bank,col), read back interleaved
    issue(CmdActivate, 2'd0, 8'd9, 6'd0, 32'h0, 4'hF);
    issue(CmdActivate, 2'd3, 8'd11, 6'd0, 32'h0, 4'hF);
    step();
    for (int i = 0; i < 8; i++) begin
      issue(CmdWrite, rb[i], 8'd0, rc[i], exp_d[i], 4'hF);
      check("ilv_wr_err", cmd_error, 0);
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        cmd_valid = 1'b1; cmd = CmdRead; bank = rb[i]; col_addr = rc[i];
      end else begin
        cmd_valid = 1'b0; cmd = CmdNop;
      end
      step();
      if (i >= 1) begin
        check("ilv_valid", read_valid, 1);
        check("ilv_data", read_data, exp_d[i-1]);
      end
    end
    step();
    check("ilv_drain", read_valid, 0);

    // Refresh interval boundary
    while (cyc < 510) step();
    check("due_before", refresh_due, 0);
    step();
    check("due_set", refresh_due, 1);
    issue(CmdRefresh, 2'd0, 8'd0, 6'd0, 32'h0, 4'hF);
    check("ref_open_err", cmd_error, 1);
    check("ref_open_rdy", cmd_ready, 1);
    check("ref_open_due", refresh_due, 1);
    issue(CmdPrechargeAll, 2'd0, 8'd0, 6'd0, 32'h0, 4'hF);
    check("pall_err", cmd_error, 0);
    step();
    issue(CmdRefresh, 2'd0, 8'd0, 6'd0, 32'h0, 4'hF);
    check("ref_err", cmd_error, 0);
    check("ref_due_clr", refresh_due, 0);
    check("ref_busy", cmd_ready, 0);
    // Command offered while busy is dropped without an error
    issue(CmdActivate, 2'd0, 8'd9, 6'd0, 32'h0, 4'hF);
    check("drop_err", cmd_error, 0);
    check("ref_busy", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("ref_busy", cmd_ready, 0);
    end
    step();
    check("ref_done", cmd_ready, 1);
    issue(CmdRead, 2'd0, 8'd0, 6'd1, 32'h0, 4'hF);
    check("drop_idle_err", cmd_error, 1);

    // Byte-masked write (full-word overwrite when the mask is not built)
    issue(CmdActivate, 2'd0, 8'd9, 6'd0, 32'h0, 4'hF);
    step();
    issue(CmdWrite, 2'd0, 8'd0, 6'd10, 32'hFFFF_FFFF, 4'b1111);
    issue(CmdWrite, 2'd0, 8'd0, 6'd10, 32'h0000_0000, 4'b0101);
    issue(CmdRead, 2'd0, 8'd0, 6'd10, 32'h0, 4'hF);
    step();
    check("mask_valid", read_valid, 1);
    check("mask_data", read_data, mask_exp);

    // Reset flushes reads in flight, keeps memory, idles banks
    issue(CmdRead, 2'd0, 8'd0, 6'd10, 32'h0, 4'hF);
    issue(CmdRead, 2'd0, 8'd0, 6'd1, 32'h0, 4'hF);
    reset = 1'b1;
    step();
    check("flush_valid", read_valid, 0);
    check("flush_data", read_data, 0);
    step();
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_nv", read_valid, 0);
    end
    check("post_rst_rdy", cmd_ready, 1);
    check("post_rst_due", refresh_due, 0);
    issue(CmdRead, 2'd0, 8'd0, 6'd10, 32'h0, 4'hF);
    check("post_rst_idle", cmd_error, 1);
    issue(CmdActivate, 2'd0, 8'd9, 6'd0, 32'h0, 4'hF);
    step();
    issue(CmdRead, 2'd0, 8'd0, 6'd1, 32'h0, 4'hF);
    check("keep_err", cmd_error, 0);
    step();
    check("keep_valid", read_valid, 1);
    check("keep_data", read_data, 32'hA000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
